matrix_frame_buffer: RTL

MATRIX_FRAME_BUFFER -- requirements
Module: matrix_frame_buffer

---
 rtl/matrix_pkg.sv | 27 ++
 rtl/matrix_frame_buffer_if.sv | 24 ++
 rtl/matrix_row_scan.sv | 40 ++++
 rtl/matrix_frame_buffer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and constants for the RGB matrix frame buffer.
package matrix_pkg;

   localparam int ROWS = 8;
   localparam int COLS = 8;

   typedef logic [COLS-1:0] row_t;

   typedef enum logic [1:0] {
      PLANE_R   = 2'd0,
      PLANE_G   = 2'd1,
      PLANE_B   = 2'd2,
      PLANE_ALL = 2'd3
   } plane_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_CLEAR     = 2'd1,
      ST_WAIT_SWAP = 2'd2
   } fb_state_t;

   // True when a write with plane select 'sel' targets colour plane 'plane'.
   function automatic logic plane_hit(input logic [1:0] sel, input logic [1:0] plane);
      return (sel == PLANE_ALL) || (sel == plane);
   endfunction

endpackage

// File: rtl/matrix_frame_buffer_if.sv
// Row-write / clear / commit bus between a frame producer and the frame buffer.
interface matrix_frame_buffer_if;
   import matrix_pkg::*;

   logic       wr_valid;
   logic       wr_ready;
   logic [2:0] wr_row;
   logic [1:0] wr_plane;
   row_t       wr_data;
   logic       clr_req;
   logic       commit;
   logic       commit_pending;

   modport master (
      output wr_valid, wr_row, wr_plane, wr_data, clr_req, commit,
      input  wr_ready, commit_pending
   );

   modport slave (
      input  wr_valid, wr_row, wr_plane, wr_data, clr_req, commit,
      output wr_ready, commit_pending
   );

endinterface

// File: rtl/matrix_row_scan.sv
// Scan row counter; advances on each scan_tick and flags the 7->0 wrap one cycle later.
module matrix_row_scan (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       scan_tick,
   output logic [2:0] scan_row,
   output logic       frame_start
);

   logic [2:0] row_q, row_d;
   logic       frame_start_q, frame_start_d;

   // Next scan row and wrap pulse.
   always_comb begin
      row_d         = row_q;
      frame_start_d = 1'b0;
      if (scan_tick) begin
         row_d         = row_q + 3'd1;
         frame_start_d = (row_q == 3'd7);
      end else begin
         row_d         = row_q;
         frame_start_d = 1'b0;
      end
   end

   // Scan state registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         row_q         <= 3'd0;
         frame_start_q <= 1'b0;
      end else begin
         row_q         <= row_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign scan_row    = row_q;
   assign frame_start = frame_start_q;

endmodule

// File: rtl/matrix_frame_buffer.sv
// Double-buffered 8x8 RGB frame store; swaps front/back only at the scan wrap to avoid tearing.
module matrix_frame_buffer #(
   parameter int ROWS = 8,
   parameter int COLS = 8
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   matrix_frame_buffer_if.slave  wr_if,
   input  logic                  scan_tick,
   output logic [2:0]            scan_row,
   output matrix_pkg::row_t      row_r,
   output matrix_pkg::row_t      row_g,
   output matrix_pkg::row_t      row_b,
   output logic                  frame_start
);
   import matrix_pkg::*;

   // Buffer index, colour plane (R/G/B), row.
   logic [COLS-1:0] fb_q [2][3][ROWS];
   logic [COLS-1:0] fb_d [2][3][ROWS];

   fb_state_t  state_q, state_d;
   logic [2:0] clr_cnt_q, clr_cnt_d;
   logic       front_sel_q, front_sel_d;
   logic       pending_q, pending_d;
   logic       wr_ready_q, wr_ready_d;
   row_t       row_r_q, row_r_d;
   row_t       row_g_q, row_g_d;
   row_t       row_b_q, row_b_d;

   logic [2:0] scan_row_s;
   logic       frame_start_s;
   logic       back_sel_s;
   logic       swap_s;

   matrix_row_scan u_row_scan (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .scan_tick   (scan_tick),
      .scan_row    (scan_row_s),
      .frame_start (frame_start_s)
   );

   assign back_sel_s = ~front_sel_q;
   // The swap lands on the same edge the scan wraps, so row 0 is the first row of the new frame.
   assign swap_s = (state_q == ST_WAIT_SWAP) && scan_tick && (scan_row_s == 3'd7);

   // Buffer update, clear sequencing, commit tracking and front/back swap.
   always_comb begin
      fb_d        = fb_q;
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      front_sel_d = front_sel_q;
      pending_d   = pending_q;
      case (state_q)
         ST_IDLE: begin
            if (wr_if.wr_valid && wr_ready_q) begin
               for (int p = 0; p < 3; p++) begin
                  if (plane_hit(wr_if.wr_plane, 2'(p))) begin
                     fb_d[back_sel_s][p][wr_if.wr_row] = wr_if.wr_data;
                  end else begin
                     fb_d[back_sel_s][p][wr_if.wr_row] = fb_q[back_sel_s][p][wr_if.wr_row];
                  end
               end
            end else begin
               fb_d = fb_q;
            end
            // A commit arriving with a clear is remembered and honoured once the clear ends.
            if (wr_if.clr_req) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = 3'd0;
               pending_d = wr_if.commit;
            end else if (wr_if.commit) begin
               state_d   = ST_WAIT_SWAP;
               pending_d = 1'b1;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            for (int p = 0; p < 3; p++) begin
               fb_d[back_sel_s][p][clr_cnt_q] = '0;
            end
            if (wr_if.commit) begin
               pending_d = 1'b1;
            end else begin
               pending_d = pending_q;
            end
            if (clr_cnt_q == 3'd7) begin
               clr_cnt_d = 3'd0;
               state_d   = (pending_q || wr_if.commit) ? ST_WAIT_SWAP : ST_IDLE;
            end else begin
               clr_cnt_d = clr_cnt_q + 3'd1;
            end
         end
         ST_WAIT_SWAP: begin
            if (swap_s) begin
               front_sel_d = ~front_sel_q;
               state_d     = ST_IDLE;
               pending_d   = 1'b0;
            end else begin
               state_d     = ST_WAIT_SWAP;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            pending_d = 1'b0;
         end
      endcase
   end

   // Ready and registered display data (inverted: LEDs are active-low).
   always_comb begin
      wr_ready_d = (state_d == ST_IDLE);
      row_r_d    = ~fb_q[front_sel_q][0][scan_row_s];
      row_g_d    = ~fb_q[front_sel_q][1][scan_row_s];
      row_b_d    = ~fb_q[front_sel_q][2][scan_row_s];
   end

   // State registers with synchronous active-low reset; reset wipes both buffers.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int b = 0; b < 2; b++) begin
            for (int p = 0; p < 3; p++) begin
               for (int r = 0; r < ROWS; r++) begin
                  fb_q[b][p][r] <= '0;
               end
            end
         end
         state_q     <= ST_IDLE;
         clr_cnt_q   <= 3'd0;
         front_sel_q <= 1'b0;
         pending_q   <= 1'b0;
         wr_ready_q  <= 1'b0;
         row_r_q     <= 8'hFF;
         row_g_q     <= 8'hFF;
         row_b_q     <= 8'hFF;
      end else begin
         fb_q        <= fb_d;
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         front_sel_q <= front_sel_d;
         pending_q   <= pending_d;
         wr_ready_q  <= wr_ready_d;
         row_r_q     <= row_r_d;
         row_g_q     <= row_g_d;
         row_b_q     <= row_b_d;
      end
   end

   assign wr_if.wr_ready       = wr_ready_q;
   assign wr_if.commit_pending = pending_q;
   assign scan_row             = scan_row_s;
   assign frame_start          = frame_start_s;
   assign row_r                = row_r_q;
   assign row_g                = row_g_q;
   assign row_b                = row_b_q;

endmodule
